ft601_device_responder: RTL and testbench

- Synthesizable device-side model of the FT601/FT245 synchronous 32-bit FIFO bus. It drives RXF_N and TXE_N and answers OE_N, RD_N and WR_N from the FPGA-side FT601 controller.
- It buffers host→FPGA words in an RX FIFO and FPGA→host words in a TX FIFO, each with a host stream port.
- It is used for on-chip loopback builds and as the counterpart in controller regression benches.

---
 rtl/ft601_resp_pkg.sv | 19 +
 rtl/ft601_device_responder_fifo.sv | 55 +++++
 rtl/ft601_device_responder.sv | 145 ++++++++++++++
 tb/tb_ft601_device_responder.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ft601_resp_pkg.sv
// FT601 device responder: shared types and constants.
// Bus FSM states, sticky error bit positions, byte-enable constant.
package ft601_resp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_TURN = 2'd1,
    RD      = 2'd2,
    WR      = 2'd3
  } resp_state_e;

  localparam int ERR_UNDERRUN = 0;
  localparam int ERR_OVERFLOW = 1;
  localparam int ERR_RD_NO_OE = 2;
  localparam int ERR_WR_IN_RD = 3;

  localparam logic [3:0] BE_ALL = 4'hF;

endpackage

// File: rtl/ft601_device_responder_fifo.sv
// First-word-fall-through synchronous FIFO.
// Exposes current and next-edge occupancy for registered flags.
module resp_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [$clog2(DEPTH):0]   next_count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_en, rd_en;

  // A push at full is accepted only when a pop frees the slot.
  assign rd_en = pop_i && (count_q != '0);
  assign wr_en = push_i && ((count_q != FULL) || rd_en);

  assign wptr_d  = wr_en ? wptr_q + AW'(1) : wptr_q;
  assign rptr_d  = rd_en ? rptr_q + AW'(1) : rptr_q;
  assign count_d = count_q + CW'(wr_en) - CW'(rd_en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= din_i;
  end

  assign dout_o       = mem_q[rptr_q];
  assign count_o      = count_q;
  assign next_count_o = count_d;

endmodule

// File: rtl/ft601_device_responder.sv
// Device-side FT601/FT245 sync FIFO bus model.
// RX FIFO feeds master reads, TX FIFO collects master writes.
module ft601_device_responder
  import ft601_resp_pkg::*;
#(
  parameter int RX_DEPTH = 16,
  parameter int TX_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ft_rxf_n,
  output logic        ft_txe_n,
  input  logic        ft_oe_n,
  input  logic        ft_rd_n,
  input  logic        ft_wr_n,
  input  logic [31:0] ft_data_i,
  input  logic [3:0]  ft_be_i,
  output logic [31:0] ft_data_o,
  output logic [3:0]  ft_be_o,
  output logic        ft_data_oe,
  input  logic [31:0] h_din,
  input  logic        h_din_valid,
  output logic        h_din_ready,
  output logic [31:0] h_dout,
  output logic [3:0]  h_dout_be,
  output logic        h_dout_valid,
  input  logic        h_dout_ready,
  output logic [3:0]  err_flags
);

  localparam int RCW = $clog2(RX_DEPTH) + 1;
  localparam int TCW = $clog2(TX_DEPTH) + 1;
  localparam logic [RCW-1:0] RX_FULL = RCW'(RX_DEPTH);
  localparam logic [TCW-1:0] TX_FULL = TCW'(TX_DEPTH);

  resp_state_e state_q, state_d;
  logic [3:0]  err_q, err_d;
  logic        init_q;
  logic        rxf_n_q, txe_n_q;

  logic [31:0]    rx_dout;
  logic [RCW-1:0] rx_count, rx_next_count;
  logic [35:0]    tx_dout;
  logic [TCW-1:0] tx_count, tx_next_count;

  logic rx_empty, rx_full, tx_empty, tx_full;
  logic rx_push, rx_pop, tx_push, tx_pop;
  logic in_read, wr_req;

  assign rx_empty = (rx_count == '0);
  assign rx_full  = (rx_count == RX_FULL);
  assign tx_empty = (tx_count == '0);
  assign tx_full  = (tx_count == TX_FULL);

  assign in_read = (state_q == RD_TURN) || (state_q == RD);
  assign wr_req  = !ft_wr_n && ((state_q == IDLE) || (state_q == WR));

  assign rx_push = h_din_valid && h_din_ready;
  assign rx_pop  = (state_q == RD) && !ft_oe_n && !ft_rd_n && !rx_empty;
  assign tx_pop  = h_dout_ready && !tx_empty;
  assign tx_push = wr_req && (!tx_full || tx_pop);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!ft_oe_n)      state_d = RD_TURN;
        else if (!ft_wr_n) state_d = WR;
      end
      RD_TURN: state_d = ft_oe_n ? IDLE : RD;
      RD:      if (ft_oe_n) state_d = IDLE;
      WR:      if (ft_wr_n) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    err_d = err_q;
    if ((state_q == RD) && !ft_oe_n && !ft_rd_n && rx_empty)
      err_d[ERR_UNDERRUN] = 1'b1;
    if (wr_req && tx_full && !tx_pop)
      err_d[ERR_OVERFLOW] = 1'b1;
    if (!ft_rd_n && ft_oe_n)
      err_d[ERR_RD_NO_OE] = 1'b1;
    if ((!ft_wr_n && in_read) || ((state_q == WR) && !ft_oe_n))
      err_d[ERR_WR_IN_RD] = 1'b1;
  end

  // Flags come from next-edge occupancy so they never lag a pop/push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      err_q   <= '0;
      init_q  <= 1'b0;
      rxf_n_q <= 1'b1;
      txe_n_q <= 1'b1;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      init_q  <= 1'b1;
      rxf_n_q <= (rx_next_count == '0);
      txe_n_q <= !(init_q && (tx_next_count != TX_FULL));
    end
  end

  resp_sync_fifo #(
    .WIDTH (32),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (rx_push),
    .din_i        (h_din),
    .pop_i        (rx_pop),
    .dout_o       (rx_dout),
    .count_o      (rx_count),
    .next_count_o (rx_next_count)
  );

  resp_sync_fifo #(
    .WIDTH (36),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (tx_push),
    .din_i        ({ft_data_i, ft_be_i}),
    .pop_i        (tx_pop),
    .dout_o       (tx_dout),
    .count_o      (tx_count),
    .next_count_o (tx_next_count)
  );

  assign ft_rxf_n     = rxf_n_q;
  assign ft_txe_n     = txe_n_q;
  assign ft_data_oe   = in_read;
  assign ft_data_o    = (in_read && !rx_empty) ? rx_dout : 32'h0;
  assign ft_be_o      = BE_ALL;
  assign err_flags    = err_q;
  assign h_din_ready  = init_q && !rx_full;
  assign h_dout       = tx_dout[35:4];
  assign h_dout_be    = tx_dout[3:0];
  assign h_dout_valid = !tx_empty;

endmodule

// File: tb/tb_ft601_device_responder.sv
// Directed testbench for ft601_device_responder.
// Each task drives one scenario and checks against hand-computed values.
module tb_ft601_device_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ft_rxf_n, ft_txe_n;
  logic        ft_oe_n, ft_rd_n, ft_wr_n;
  logic [31:0] ft_data_i, ft_data_o;
  logic [3:0]  ft_be_i, ft_be_o;
  logic        ft_data_oe;
  logic [31:0] h_din;
  logic        h_din_valid, h_din_ready;
  logic [31:0] h_dout;
  logic [3:0]  h_dout_be;
  logic        h_dout_valid, h_dout_ready;
  logic [3:0]  err_flags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ft601_device_responder #(
    .RX_DEPTH (16),
    .TX_DEPTH (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ft_rxf_n     (ft_rxf_n),
    .ft_txe_n     (ft_txe_n),
    .ft_oe_n      (ft_oe_n),
    .ft_rd_n      (ft_rd_n),
    .ft_wr_n      (ft_wr_n),
    .ft_data_i    (ft_data_i),
    .ft_be_i      (ft_be_i),
    .ft_data_o    (ft_data_o),
    .ft_be_o      (ft_be_o),
    .ft_data_oe   (ft_data_oe),
    .h_din        (h_din),
    .h_din_valid  (h_din_valid),
    .h_din_ready  (h_din_ready),
    .h_dout       (h_dout),
    .h_dout_be    (h_dout_be),
    .h_dout_valid (h_dout_valid),
    .h_dout_ready (h_dout_ready),
    .err_flags    (err_flags)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ft_oe_n = 1'b1; ft_rd_n = 1'b1; ft_wr_n = 1'b1;
    ft_data_i = '0; ft_be_i = '0;
    h_din = '0; h_din_valid = 1'b0; h_dout_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
  endtask

  task automatic host_push(input logic [31:0] w);
    h_din = w; h_din_valid = 1'b1;
    tick();
    h_din_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({ft_rxf_n, ft_txe_n, ft_data_oe, h_din_ready, h_dout_valid} !== 5'b11000) begin
      errors++;
      $display("FAIL reset_flags got=%b want=11000",
               {ft_rxf_n, ft_txe_n, ft_data_oe, h_din_ready, h_dout_valid});
    end
    checks++;
    if (ft_data_o !== 32'h0 || err_flags !== 4'h0 || ft_be_o !== 4'hF) begin
      errors++;
      $display("FAIL reset_data got=%h/%h/%h", ft_data_o, err_flags, ft_be_o);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (h_din_ready !== 1'b1 || ft_txe_n !== 1'b1) begin
      errors++;
      $display("FAIL reset_edge1 ready=%b txe_n=%b want 1/1", h_din_ready, ft_txe_n);
    end
    tick();
    checks++;
    if (ft_txe_n !== 1'b0) begin
      errors++;
      $display("FAIL reset_edge2 txe_n=%b want 0", ft_txe_n);
    end
  endtask

  task automatic test_rx_read();
    logic [31:0] exp_w [3];
    exp_w[0] = 32'h11111111; exp_w[1] = 32'h22222222; exp_w[2] = 32'h33333333;
    host_push(exp_w[0]);
    checks++;
    if (ft_rxf_n !== 1'b0) begin
      errors++;
      $display("FAIL rx_rxf_low got=%b want 0", ft_rxf_n);
    end
    host_push(exp_w[1]);
    host_push(exp_w[2]);
    ft_oe_n = 1'b0;
    tick();
    checks++;
    if (ft_data_oe !== 1'b1 || ft_data_o !== exp_w[0]) begin
      errors++;
      $display("FAIL rx_turn oe=%b data=%h want 1/%h", ft_data_oe, ft_data_o, exp_w[0]);
    end
    tick();
    ft_rd_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ft_data_o !== exp_w[i]) begin
        errors++;
        $display("FAIL rx_word%0d got=%h want=%h", i, ft_data_o, exp_w[i]);
      end
      tick();
    end
    checks++;
    if (ft_rxf_n !== 1'b1 || ft_data_o !== 32'h0 || err_flags !== 4'h0) begin
      errors++;
      $display("FAIL rx_after rxf_n=%b data=%h err=%h want 1/0/0",
               ft_rxf_n, ft_data_o, err_flags);
    end
    ft_rd_n = 1'b1; ft_oe_n = 1'b1;
    tick();
    checks++;
    if (ft_data_oe !== 1'b0) begin
      errors++;
      $display("FAIL rx_release oe=%b want 0", ft_data_oe);
    end
  endtask

  task automatic test_tx_fill_drain();
    ft_be_i = 4'hF;
    ft_wr_n = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ft_data_i = i;
      tick();
      if (i == 14) begin
        checks++;
        if (ft_txe_n !== 1'b0) begin
          errors++;
          $display("FAIL tx_txe_15 got=%b want 0", ft_txe_n);
        end
      end
    end
    checks++;
    if (ft_txe_n !== 1'b1) begin
      errors++;
      $display("FAIL tx_txe_full got=%b want 1", ft_txe_n);
    end
    ft_data_i = 32'hDEADBEEF;
    tick();
    checks++;
    if (err_flags !== 4'b0010) begin
      errors++;
      $display("FAIL tx_overflow err=%b want 0010", err_flags);
    end
    ft_wr_n = 1'b1;
    tick();
    h_dout_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (h_dout_valid !== 1'b1 || h_dout !== 32'(i) || h_dout_be !== 4'hF) begin
        errors++;
        $display("FAIL tx_drain%0d v=%b got=%h be=%h want %h/F",
                 i, h_dout_valid, h_dout, h_dout_be, i);
      end
      tick();
    end
    h_dout_ready = 1'b0;
    checks++;
    if (h_dout_valid !== 1'b0 || ft_txe_n !== 1'b0) begin
      errors++;
      $display("FAIL tx_empty v=%b txe_n=%b want 0/0", h_dout_valid, ft_txe_n);
    end
  endtask

  task automatic test_full_simul();
    do_reset();
    ft_be_i = 4'hF;
    ft_wr_n = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ft_data_i = 32'h100 + i;
      tick();
    end
    ft_data_i = 32'hA5A5A5A5;
    h_dout_ready = 1'b1;
    tick();
    ft_wr_n = 1'b1; h_dout_ready = 1'b0;
    checks++;
    if (err_flags !== 4'h0 || ft_txe_n !== 1'b1) begin
      errors++;
      $display("FAIL full_simul err=%h txe_n=%b want 0/1", err_flags, ft_txe_n);
    end
    tick();
    h_dout_ready = 1'b1;
    for (int i = 1; i < 16; i++) tick();
    checks++;
    if (h_dout !== 32'hA5A5A5A5 || h_dout_valid !== 1'b1) begin
      errors++;
      $display("FAIL full_last got=%h v=%b want a5a5a5a5/1", h_dout, h_dout_valid);
    end
    tick();
    h_dout_ready = 1'b0;
    checks++;
    if (h_dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_drained v=%b want 0", h_dout_valid);
    end
  endtask

  task automatic test_underrun();
    ft_oe_n = 1'b0;
    tick();
    tick();
    ft_rd_n = 1'b0;
    tick();
    tick();
    checks++;
    if (err_flags !== 4'b0001 || ft_data_o !== 32'h0) begin
      errors++;
      $display("FAIL underrun err=%b data=%h want 0001/0", err_flags, ft_data_o);
    end
    ft_oe_n = 1'b1; ft_rd_n = 1'b1;
    tick();
    ft_rd_n = 1'b0;
    tick();
    ft_rd_n = 1'b1;
    checks++;
    if (err_flags !== 4'b0101) begin
      errors++;
      $display("FAIL rd_no_oe err=%b want 0101", err_flags);
    end
    host_push(32'h77777777);
    ft_oe_n = 1'b0;
    tick();
    tick();
    checks++;
    if (ft_data_o !== 32'h77777777) begin
      errors++;
      $display("FAIL underrun_ptr got=%h want 77777777", ft_data_o);
    end
    ft_oe_n = 1'b1;
    tick();
  endtask

  task automatic test_wr_in_rd();
    ft_oe_n = 1'b0;
    tick();
    tick();
    ft_wr_n = 1'b0; ft_data_i = 32'h0BAD0BAD; ft_be_i = 4'hF;
    tick();
    ft_wr_n = 1'b1; ft_oe_n = 1'b1;
    checks++;
    if (err_flags !== 4'b1101 || h_dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL wr_in_rd err=%b v=%b want 1101/0", err_flags, h_dout_valid);
    end
    tick();
    checks++;
    if (ft_txe_n !== 1'b0 || h_dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL wr_in_rd_cnt txe_n=%b v=%b want 0/0", ft_txe_n, h_dout_valid);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) host_push(32'hC0 + i);
    ft_rd_n = 1'b0;
    tick();
    ft_rd_n = 1'b1;
    ft_oe_n = 1'b0;
    tick();
    tick();
    checks++;
    if (ft_data_oe !== 1'b1 || err_flags !== 4'b0100 || ft_data_o !== 32'hC0) begin
      errors++;
      $display("FAIL mid_pre oe=%b err=%b data=%h want 1/0100/c0",
               ft_data_oe, err_flags, ft_data_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ft_data_oe !== 1'b0 || ft_rxf_n !== 1'b1 || err_flags !== 4'h0 ||
        h_din_ready !== 1'b0 || h_dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset oe=%b rxf_n=%b err=%h rdy=%b v=%b want 0/1/0/0/0",
               ft_data_oe, ft_rxf_n, err_flags, h_din_ready, h_dout_valid);
    end
    idle_inputs();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if (ft_rxf_n !== 1'b1 || h_din_ready !== 1'b1 || ft_txe_n !== 1'b0) begin
      errors++;
      $display("FAIL mid_after rxf_n=%b rdy=%b txe_n=%b want 1/1/0",
               ft_rxf_n, h_din_ready, ft_txe_n);
    end
  endtask

  initial begin
    test_reset();
    test_rx_read();
    test_tx_fill_drain();
    test_full_simul();
    test_underrun();
    test_wr_in_rd();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
